keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with full-scan debounce.
// Drives one active-low column per dwell period, samples the synchronized
// rows at the end of each dwell, and debounces complete 4-column scan results
// into a one-cycle key_valid pulse, a held key_down level and a sticky key_code.
module keypad_scan #(
  parameter int SCAN_TICKS = 50000,  // clk50MHz cycles per column dwell, >= 4
  parameter int DEB_COUNT  = 8       // identical scans to accept press/release, 1..255
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int              DIV_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_TICKS - 1);
  localparam logic [7:0]      DEB_LAST = 8'(DEB_COUNT);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic             r_scan_hit;
  logic [3:0]       r_scan_code;
  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_down;

  logic             w_tick;
  logic             w_scan_end;
  logic             w_row_hit;
  logic [1:0]       w_row_pos;
  logic             w_scan_pressed;
  logic [3:0]       w_scan_code;
  logic [7:0]       w_cnt_inc;

  assign w_tick         = (r_div == DIV_LAST);
  assign w_scan_end     = w_tick && (r_idx == 2'd3);
  assign w_row_hit      = (r_row_sync != 4'b1111);
  // Earlier columns already scanned take priority over the current column.
  assign w_scan_pressed = r_scan_hit | w_row_hit;
  assign w_scan_code    = r_scan_hit ? r_scan_code : {w_row_pos, 2'd3};
  assign w_cnt_inc      = r_cnt + 8'd1;

  assign col       = ~(4'b0001 << r_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

  // Lowest-numbered active (low) row of the currently driven column.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_row_pos unassigned (no latch).
    w_row_pos = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_row_sync[r]) w_row_pos = 2'(r);
    end
  end

  // Two-flop synchronizer for the asynchronous row lines; idle level is all-ones.
  always_ff @(posedge clk50MHz) begin
    // NOTE: non-blocking assignments so both flops sample pre-edge values.
    if (rst) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
    end
  end

  // Dwell divider and column index; the index advances on each tick.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Accumulate the first hit of a scan over columns 0..2; cleared at scan end.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_scan_hit  <= 1'b0;
      r_scan_code <= 4'd0;
    end else if (w_tick) begin
      if (r_idx == 2'd3) begin
        r_scan_hit  <= 1'b0;
        r_scan_code <= 4'd0;
      end else if (!r_scan_hit && w_row_hit) begin
        r_scan_hit  <= 1'b1;
        r_scan_code <= {w_row_pos, r_idx};
      end
    end
  end

  // Debounce FSM, evaluated only on complete scan results.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_cand      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_scan_end) begin
        case (r_state)
          ST_IDLE: begin
            if (w_scan_pressed) begin
              r_cand <= w_scan_code;
              if (DEB_COUNT == 1) begin
                r_state     <= ST_HELD;
                r_cnt       <= 8'd0;
                r_key_code  <= w_scan_code;
                r_key_down  <= 1'b1;
                r_key_valid <= 1'b1;
              end else begin
                r_state <= ST_PRESS_WAIT;
                r_cnt   <= 8'd1;
              end
            end
          end
          ST_PRESS_WAIT: begin
            if (w_scan_pressed && (w_scan_code == r_cand)) begin
              if (w_cnt_inc == DEB_LAST) begin
                r_state     <= ST_HELD;
                r_cnt       <= 8'd0;
                r_key_code  <= r_cand;
                r_key_down  <= 1'b1;
                r_key_valid <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= 8'd0;
            end
          end
          ST_HELD: begin
            if (!(w_scan_pressed && (w_scan_code == r_key_code))) begin
              // The first non-matching scan already counts toward release.
              if (DEB_COUNT == 1) begin
                r_state    <= ST_IDLE;
                r_cnt      <= 8'd0;
                r_key_down <= 1'b0;
              end else begin
                r_state <= ST_RELEASE_WAIT;
                r_cnt   <= 8'd1;
              end
            end
          end
          ST_RELEASE_WAIT: begin
            if (!w_scan_pressed) begin
              if (w_cnt_inc == DEB_LAST) begin
                r_state    <= ST_IDLE;
                r_cnt      <= 8'd0;
                r_key_down <= 1'b0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else if (w_scan_code == r_key_code) begin
              r_state <= ST_HELD;
              r_cnt   <= 8'd0;
            end else begin
              // A different key restarts the release count; no rollover.
              r_cnt <= 8'd0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed stimulus for keypad_scan with a keypad matrix model
// driving the rows from the column outputs, a scan/debounce reference model
// compared every cycle, and hand-computed literal checkpoints.
module tb_keypad_scan;

  localparam int S    = 4;
  localparam int D    = 2;
  localparam int SCAN = 4 * S;

  logic        clk50MHz = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] keys;      // bit {row,col} set = that key is physically pressed
  logic        cmp_en = 1'b0;
  logic        prev_valid = 1'b0;
  int          n_valid = 0;
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  int          m_t = 0;
  int          m_run = 0;
  int          m_miss = 0;
  bit          m_down = 1'b0;
  bit          m_rel = 1'b0;
  logic [3:0]  m_cand = 4'd0;
  logic [3:0]  e_col = 4'hE;
  logic [3:0]  e_code = 4'd0;
  logic        e_valid = 1'b0;

  always #10 clk50MHz = ~clk50MHz;

  keypad_scan #(.SCAN_TICKS(S), .DEB_COUNT(D)) dut (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  // Physical matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50MHz);
  endtask

  // Reference model: time since reset defines column and scan ends; each scan
  // end applies the debounce rules to the whole-matrix scan result.
  always @(posedge clk50MHz) begin
    bit         p;
    logic [3:0] c_code;
    if (rst) begin
      m_t = 0; m_run = 0; m_miss = 0; m_down = 0; m_rel = 0;
      m_cand = 4'd0; e_code = 4'd0; e_valid = 1'b0;
    end else begin
      e_valid = 1'b0;
      if ((m_t % S == S - 1) && ((m_t / S) % 4 == 3)) begin
        p = 1'b0; c_code = 4'd0;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            if (!p && keys[r*4+c]) begin p = 1'b1; c_code = 4'(r*4+c); end
        if (!m_down) begin
          if (p && m_run > 0 && c_code == m_cand) m_run++;
          else if (p && m_run == 0) begin m_run = 1; m_cand = c_code; end
          else m_run = 0;
          if (m_run == D) begin
            m_down = 1; e_code = m_cand; e_valid = 1'b1; m_run = 0;
          end
        end else begin
          if (p && c_code == e_code) begin m_rel = 0; m_miss = 0; end
          else if (!m_rel) begin m_rel = 1; m_miss = 1; end
          else if (p) m_miss = 0;
          else m_miss++;
          if (m_rel && m_miss == D) begin m_down = 0; m_rel = 0; m_miss = 0; end
        end
      end
      m_t++;
    end
    e_col = 4'hF;
    e_col[(m_t / S) % 4] = 1'b0;
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk50MHz) begin
    if (cmp_en) begin
      check("col",        32'(col),       32'(e_col));
      check("key_code",   32'(key_code),  32'(e_code));
      check("key_valid",  32'(key_valid), 32'(e_valid));
      check("key_down",   32'(key_down),  32'(m_down));
      check("valid_twice", 32'(key_valid & prev_valid), 32'd0);
      prev_valid = key_valid;
      if (key_valid === 1'b1) n_valid++;
    end
  end

  initial begin
    logic [3:0] col_exp [5];
    col_exp = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    keys = 16'h0000;
    rst  = 1'b1;
    @(negedge clk50MHz);
    @(negedge clk50MHz);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Reset state, then idle column rotation with 4-cycle dwell.
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_down",  32'(key_down),  32'd0);
    for (int k = 0; k < 5; k++) begin
      check("idle_col", 32'(col), 32'(col_exp[k]));
      cycles(4);
    end
    cycles(12);

    // Stable press of row1/col2: pulse one cycle after the 2nd scan end.
    keys = 16'h0040;
    cycles(31);
    check("press_pre_valid", 32'(key_valid), 32'd0);
    cycles(1);
    check("press_valid", 32'(key_valid), 32'd1);
    check("press_code",  32'(key_code),  32'h6);
    check("press_down",  32'(key_down),  32'd1);
    cycles(1);
    check("press_valid_end", 32'(key_valid), 32'd0);
    cycles(15 + SCAN);
    check("press_count", 32'(n_valid), 32'd1);

    // One-scan release glitch while held: stays down, no second pulse.
    keys = 16'h0000;
    cycles(SCAN);
    keys = 16'h0040;
    cycles(SCAN);
    check("glitch_down",  32'(key_down), 32'd1);
    check("glitch_count", 32'(n_valid),  32'd1);

    // Full release for two scans: down drops, code sticks.
    keys = 16'h0000;
    cycles(2 * SCAN - 1);
    check("release_pre_down", 32'(key_down), 32'd1);
    cycles(1);
    check("release_down", 32'(key_down), 32'd0);
    check("release_code", 32'(key_code), 32'h6);

    // Single-scan press: rejected.
    keys = 16'h0040;
    cycles(SCAN);
    keys = 16'h0000;
    cycles(2 * SCAN);
    check("short_count", 32'(n_valid),  32'd1);
    check("short_down",  32'(key_down), 32'd0);

    // row0/col3 with row2/col1: lower column wins -> code 9.
    keys = 16'h0208;
    cycles(3 * SCAN);
    check("multi_code",  32'(key_code), 32'h9);
    check("multi_down",  32'(key_down), 32'd1);
    check("multi_count", 32'(n_valid),  32'd2);
    keys = 16'h0000;
    cycles(2 * SCAN);
    check("multi_release", 32'(key_down), 32'd0);

    // Reset during PRESS_WAIT aborts the pending press.
    keys = 16'h0040;
    cycles(SCAN + 4);
    rst = 1'b1;
    cycles(1);
    check("abort_col",   32'(col),       32'hE);
    check("abort_valid", 32'(key_valid), 32'd0);
    check("abort_down",  32'(key_down),  32'd0);
    check("abort_code",  32'(key_code),  32'd0);
    keys = 16'h0000;
    rst  = 1'b0;
    cycles(3 * SCAN);
    check("abort_count", 32'(n_valid),  32'd2);
    check("abort_idle",  32'(key_down), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
